pc_gen_ras: RTL and testbench

//  Registered next-PC generator for the WISC fetch stage. Successor to the combinational next-PC logic.

---
 rtl/pc_gen_ras_pkg.sv | 39 +++
 rtl/pc_gen_ras_ras_stack.sv | 74 +++++++
 rtl/pc_gen_ras.sv | 119 +++++++++++
 tb/tb_pc_gen_ras.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_ras_pkg.sv
// Shared definitions for the WISC next-PC generator.
//   cond_e      : branch condition codes as encoded in the instruction
//   cond_taken  : evaluates a condition code against the ALU flags
//   DEF_*       : default parameter values for pc_gen_ras
package pc_gen_ras_pkg;

  typedef enum logic [2:0] {
    COND_NE  = 3'b000,
    COND_EQ  = 3'b001,
    COND_GT  = 3'b010,
    COND_LT  = 3'b011,
    COND_GE  = 3'b100,
    COND_LE  = 3'b101,
    COND_OV  = 3'b110,
    COND_UNC = 3'b111
  } cond_e;

  localparam int unsigned DEF_PC_W      = 16;
  localparam int unsigned DEF_RAS_DEPTH = 8;

  function automatic logic cond_taken(input logic [2:0] cond,
                                      input logic z, input logic v, input logic n);
    logic t;
    t = 1'b0;
    case (cond_e'(cond))
      COND_NE:  t = !z;
      COND_EQ:  t = z;
      COND_GT:  t = !z && !n;
      COND_LT:  t = n;
      COND_GE:  t = !n;
      COND_LE:  t = n || z;
      COND_OV:  t = v;
      COND_UNC: t = 1'b1;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pc_gen_ras_ras_stack.sv
// Hardware return-address stack as a circular buffer.
// Ports:
//   clk, rst     clock / synchronous active-high reset (clears count, pointer, ovf)
//   push, pop    push wins when both are asserted; pop on empty is ignored
//   push_data    value pushed
//   top          most recently pushed valid entry (undefined when empty)
//   empty, full  occupancy status
//   ovf          sticky: a push happened while full and overwrote the oldest entry
// DEPTH must be a power of two >= 2 so the pointer wraps naturally.
module ras_stack
  import pc_gen_ras_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;   // next slot to write; top lives one below
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] top_idx;

  assign top_idx = wr_ptr_q - PW'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign ovf     = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      // When full the write lands on the oldest entry, so occupancy stays put.
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + (PW+1)'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - PW'(1);
      count_d  = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Registered next-PC generator with a hardware return-address stack.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   stall                    freeze PC and RAS for this cycle
//   branch, call, ret, halt  decoded control for the current instruction
//   cond, z, v, n            branch condition code and ALU flags
//   b_imm, c_imm             sign-extended branch / call offsets
//   ret_addr                 register-file return address used when the RAS is empty
//   pc, pc_plus1             registered PC and its combinational successor
//   halted                   sticky halt status, cleared only by rst
//   ras_empty, ras_full      RAS occupancy
//   ras_ovf                  sticky RAS overwrite indicator
//   ras_miss                 one-cycle pulse, aligned with pc taking ret_addr
// Each cycle one action is chosen in order:
//   rst > halted > stall > halt > call > ret > branch > sequential.
// The decision made in cycle t shows on pc (and the RAS) at t+1.
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic            halt,
  input  logic [2:0]      cond,
  input  logic            z,
  input  logic            v,
  input  logic            n,
  input  logic [PC_W-1:0] b_imm,
  input  logic [PC_W-1:0] c_imm,
  input  logic [PC_W-1:0] ret_addr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            halted,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_miss
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            ras_miss_q, ras_miss_d;
  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            taken;

  assign pc_plus1 = pc_q + PC_W'(1);
  assign taken    = cond_taken(cond, z, v, n);

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf)
  );

  always_comb begin
    pc_d       = pc_q;
    halted_d   = halted_q;
    ras_miss_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (halted_q) begin
      ras_miss_d = ras_miss_q;
    end else if (stall) begin
      // Everything holds; a pending halt is picked up once the stall drops.
    end else if (halt) begin
      halted_d = 1'b1;
    end else if (call) begin
      // A simultaneous ret is dropped here, so no pop happens.
      ras_push = 1'b1;
      pc_d     = pc_plus1 + c_imm;
    end else if (ret) begin
      if (!ras_empty) begin
        ras_pop = 1'b1;
        pc_d    = ras_top;
      end else begin
        pc_d       = ret_addr;
        ras_miss_d = 1'b1;
      end
    end else if (branch) begin
      pc_d = taken ? (pc_plus1 + b_imm) : pc_plus1;
    end else begin
      pc_d = pc_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      halted_q   <= 1'b0;
      ras_miss_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      halted_q   <= halted_d;
      ras_miss_q <= ras_miss_d;
    end
  end

  assign pc       = pc_q;
  assign halted   = halted_q;
  assign ras_miss = ras_miss_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras (PC_W=16, RAS_DEPTH=8, RESET_PC=5).
// The driver applies one cycle of inputs and queues the hand-computed state
// expected after that edge; the monitor compares on the falling edge.
module tb_pc_gen_ras;
  import pc_gen_ras_pkg::*;

  localparam int W  = 16;
  localparam int EW = W + 5;   // {pc, halted, empty, full, ovf, miss}

  // flag patterns: {halted, empty, full, ovf, miss}
  localparam logic [4:0] F_NONE  = 5'b00000;
  localparam logic [4:0] F_EMPTY = 5'b01000;
  localparam logic [4:0] F_HALTE = 5'b11000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall, branch, call, ret, halt;
  logic [2:0]   cond;
  logic         z, v, n;
  logic [W-1:0] b_imm, c_imm, ret_addr;
  logic [W-1:0] pc, pc_plus1;
  logic         halted, ras_empty, ras_full, ras_ovf, ras_miss;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  pc_gen_ras #(
    .PC_W      (W),
    .RAS_DEPTH (8),
    .RESET_PC  (16'd5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .branch    (branch),
    .call      (call),
    .ret       (ret),
    .halt      (halt),
    .cond      (cond),
    .z         (z),
    .v         (v),
    .n         (n),
    .b_imm     (b_imm),
    .c_imm     (c_imm),
    .ret_addr  (ret_addr),
    .pc        (pc),
    .pc_plus1  (pc_plus1),
    .halted    (halted),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_miss  (ras_miss)
  );

  // clock
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_ctl();
    stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0;
    cond = 3'b000; z = 1'b0; v = 1'b0; n = 1'b0;
    b_imm = '0; c_imm = '0; ret_addr = 16'd30;
  endtask

  task automatic tick(input string nm, input logic [W-1:0] epc, input logic [4:0] ef);
    @(posedge clk);
    exp_q.push_back({epc, ef});
    name_q.push_back(nm);
    #1;
    rst = 1'b0;
    clear_ctl();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick("reset", 16'd5, F_EMPTY);
  endtask

  function automatic logic ref_taken(input int c, input logic fz, input logic fv, input logic fn);
    case (c)
      0: return !fz;
      1: return fz;
      2: return !fz && !fn;
      3: return fn;
      4: return !fn;
      5: return fn || fz;
      6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  // scoreboard monitor
  logic [EW-1:0] mon_exp, mon_got;
  logic [W-1:0]  mon_p1;
  string         mon_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_got = {pc, halted, ras_empty, ras_full, ras_ovf, ras_miss};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s: got pc=%h flags(h,e,f,o,m)=%b, expected pc=%h flags=%b",
                 mon_nm, mon_got[EW-1:5], mon_got[4:0], mon_exp[EW-1:5], mon_exp[4:0]);
      end
      mon_p1 = mon_exp[EW-1:5] + 16'd1;
      checks++;
      if (pc_plus1 !== mon_p1) begin
        errors++;
        $display("FAIL %s pc_plus1: got %h, expected %h", mon_nm, pc_plus1, mon_p1);
      end
    end
  end

  logic [W-1:0] epc;
  logic         tk;

  initial begin
    clear_ctl();

    // 1: reset then sequential fetch
    reset_dut();
    tick("seq1", 16'd6, F_EMPTY);
    tick("seq2", 16'd7, F_EMPTY);
    tick("seq3", 16'd8, F_EMPTY);

    // 2: directed branches
    reset_dut();
    branch = 1'b1; cond = 3'b011; z = 1'b0; n = 1'b1; b_imm = 16'd10;
    tick("br_lt_taken", 16'd16, F_EMPTY);
    reset_dut();
    branch = 1'b1; cond = 3'b001; z = 1'b0; n = 1'b1; b_imm = 16'd10;
    tick("br_eq_not_taken", 16'd6, F_EMPTY);

    // 2: every condition over every flag combination
    reset_dut();
    epc = 16'd5;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        branch = 1'b1; cond = c[2:0];
        z = f[2]; v = f[1]; n = f[0];
        b_imm = 16'd100;
        tk  = ref_taken(c, f[2], f[1], f[0]);
        epc = epc + 16'd1 + (tk ? 16'd100 : 16'd0);
        tick($sformatf("br_sweep c%0d zvn%0d", c, f), epc, F_EMPTY);
      end
    end

    // 3: call then ret
    reset_dut();
    call = 1'b1; c_imm = 16'd20;
    tick("call", 16'd26, F_NONE);
    ret = 1'b1;
    tick("ret", 16'd6, F_EMPTY);

    // 4: overflow, newest-first returns, miss on empty
    reset_dut();
    for (int k = 1; k <= 9; k++) begin
      call = 1'b1; c_imm = 16'd0;
      tick($sformatf("fill call%0d", k), 16'(5 + k),
           {1'b0, 1'b0, (k >= 8), (k == 9), 1'b0});
    end
    for (int j = 1; j <= 8; j++) begin
      ret = 1'b1;
      tick($sformatf("drain ret%0d", j), 16'(15 - j),
           {1'b0, (j == 8), 1'b0, 1'b1, 1'b0});
    end
    ret = 1'b1; ret_addr = 16'd30;
    tick("ret_miss", 16'd30, 5'b01011);
    tick("after_miss", 16'd31, 5'b01010);

    // 5: halt is sticky until reset
    reset_dut();
    halt = 1'b1;
    tick("halt", 16'd5, F_HALTE);
    call = 1'b1; c_imm = 16'd20;
    tick("halted_call", 16'd5, F_HALTE);
    ret = 1'b1;
    tick("halted_ret", 16'd5, F_HALTE);
    branch = 1'b1; cond = 3'b111; b_imm = 16'd9;
    tick("halted_branch", 16'd5, F_HALTE);
    reset_dut();
    tick("unhalt_seq", 16'd6, F_EMPTY);

    // 6: stall, call+ret priority, wrap
    reset_dut();
    call = 1'b1; c_imm = 16'd20;
    tick("call_pre_stall", 16'd26, F_NONE);
    stall = 1'b1; call = 1'b1; c_imm = 16'd20;
    tick("stall_call", 16'd26, F_NONE);
    stall = 1'b1; halt = 1'b1;
    tick("stall_halt", 16'd26, F_NONE);
    call = 1'b1; ret = 1'b1; c_imm = 16'd3;
    tick("call_and_ret", 16'd30, F_NONE);
    ret = 1'b1;
    tick("ret_after_both", 16'd27, F_NONE);
    ret = 1'b1;
    tick("ret_oldest", 16'd6, F_EMPTY);
    stall = 1'b1; ret = 1'b1;
    tick("stall_ret_empty", 16'd6, F_EMPTY);
    reset_dut();
    branch = 1'b1; cond = 3'b111; b_imm = 16'hFFF9;
    tick("br_back", 16'hFFFF, F_EMPTY);
    tick("wrap", 16'h0000, F_EMPTY);
    tick("after_wrap", 16'h0001, F_EMPTY);

    // drain and report
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
